// File: rtl/div_share_sched_pkg.sv
// Shared defaults, response flag encodings and FSM state type for the divider scheduler.
package div_share_sched_pkg;

  localparam int unsigned AW_DEF = 27;
  localparam int unsigned BW_DEF = 27;
  localparam int unsigned QW_DEF = 16;

  localparam logic [1:0] FLAG_OK = 2'b00;
  localparam logic [1:0] FLAG_DZ = 2'b01;
  localparam logic [1:0] FLAG_TO = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/div_share_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after i_ptr, wrapping.
module div_share_sched_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic w_found;

  // Scan from the pointer and stop at the first asserted request.
  always_comb begin
    int unsigned pos;
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (int'(i_ptr) + k) % NREQ;
      if (!w_found && i_req[pos]) begin
        w_found       = 1'b1;
        o_onehot[pos] = 1'b1;
        o_idx         = IW'(pos);
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/div_share_sched.sv
// Shares one multi-cycle unsigned divider among NREQ requesters: round-robin grant,
// sign/magnitude handling, divide-by-zero bypass with saturation and a WAIT watchdog.
module div_share_sched
  import div_share_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned AW      = AW_DEF,
  parameter int unsigned BW      = BW_DEF,
  parameter int unsigned QW      = QW_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NREQ-1:0]  i_req,
  input  logic [NREQ*AW-1:0] i_a,
  input  logic [NREQ*BW-1:0] i_b,
  output logic [NREQ-1:0]  o_gnt,
  output logic [NREQ-1:0]  o_rsp_vld,
  output logic [QW-1:0]    o_rsp_q,
  output logic [1:0]       o_rsp_flag,
  output logic             o_busy,
  output logic             o_div_en,
  output logic [AW-1:0]    o_div_a,
  output logic [BW-1:0]    o_div_b,
  input  logic             i_div_fin,
  input  logic [QW-1:0]    i_div_q
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};

  state_e          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_neg, w_neg_nxt;
  logic [AW-1:0]   r_mag, w_mag_nxt;
  logic [BW-1:0]   r_b, w_b_nxt;
  logic [QW-1:0]   r_q, w_q_nxt;
  logic [1:0]      r_flag, w_flag_nxt;

  logic [NREQ-1:0] w_onehot;
  logic [IW-1:0]   w_pick;
  logic            w_any;
  logic [AW-1:0]   w_a_sel;
  logic [BW-1:0]   w_b_sel;
  logic [AW-1:0]   w_a_mag;

  div_share_sched_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_onehot(w_onehot),
    .o_idx   (w_pick),
    .o_any   (w_any)
  );

  // Most-negative dividend negates to 2^(AW-1), which still fits as an unsigned AW-bit value.
  assign w_a_sel = i_a[w_pick*AW +: AW];
  assign w_b_sel = i_b[w_pick*BW +: BW];
  assign w_a_mag = w_a_sel[AW-1] ? (~w_a_sel + 1'b1) : w_a_sel;

  // Apply sign to the divider magnitude, clamping to the signed QW range.
  function automatic logic [QW-1:0] f_sign_sat(input logic neg, input logic [QW-1:0] mag);
    if (neg) return (mag > Q_MIN) ? Q_MIN : (~mag + 1'b1);
    return (mag > Q_MAX) ? Q_MAX : mag;
  endfunction

  // Next-state and captured-operand logic for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_neg_nxt   = r_neg;
    w_mag_nxt   = r_mag;
    w_b_nxt     = r_b;
    w_q_nxt     = r_q;
    w_flag_nxt  = r_flag;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_gnt_nxt = w_onehot;
          w_idx_nxt = w_pick;
          w_neg_nxt = w_a_sel[AW-1];
          w_mag_nxt = w_a_mag;
          w_b_nxt   = w_b_sel;
          if (w_b_sel == '0) begin
            w_q_nxt     = w_a_sel[AW-1] ? Q_MIN : Q_MAX;
            w_flag_nxt  = FLAG_DZ;
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A finish arriving on the last watchdog cycle still counts as a good result.
        if (i_div_fin) begin
          w_q_nxt     = f_sign_sat(r_neg, i_div_q);
          w_flag_nxt  = FLAG_OK;
          w_state_nxt = S_RESP;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_q_nxt     = '0;
          w_flag_nxt  = FLAG_TO;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_RESP: begin
        w_ptr_nxt   = (r_idx == IW'(NREQ - 1)) ? '0 : r_idx + IW'(1);
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction without a response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_neg   <= 1'b0;
      r_mag   <= '0;
      r_b     <= '0;
      r_q     <= '0;
      r_flag  <= FLAG_OK;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_neg   <= w_neg_nxt;
      r_mag   <= w_mag_nxt;
      r_b     <= w_b_nxt;
      r_q     <= w_q_nxt;
      r_flag  <= w_flag_nxt;
    end
  end

  // Response fields are forced to zero outside the single RESP cycle.
  always_comb begin
    o_gnt      = r_gnt;
    o_busy     = (r_state != S_IDLE);
    o_div_en   = (r_state == S_ISSUE);
    o_div_a    = r_mag;
    o_div_b    = r_b;
    o_rsp_vld  = '0;
    o_rsp_q    = '0;
    o_rsp_flag = FLAG_OK;
    if (r_state == S_RESP) begin
      o_rsp_vld  = r_gnt;
      o_rsp_q    = r_q;
      o_rsp_flag = r_flag;
    end
  end

endmodule
